// File: rtl/dlx_mem_responder_if.sv
// Bus between the DLX core's memory-access control (master) and the memory responder (slave).
// Carries the AS_N/WR_N strobes, address, write data, read data and ACK_N.
interface dlx_mem_responder_if;
    logic        AS_N;
    logic        WR_N;
    logic [31:0] AO;
    logic [31:0] DO;
    logic [31:0] DI;
    logic        ACK_N;

    modport master (output AS_N, WR_N, AO, DO, input DI, ACK_N);
    modport slave  (input AS_N, WR_N, AO, DO, output DI, ACK_N);
endinterface

// File: rtl/dlx_mem_responder.sv
// DLX bus memory responder: wait-stated AS_N/ACK_N target with a host preload port.
// Optional macro DLX_MEM_RANGE_CHECK_EN flags requests whose AO exceeds the memory depth.
module dlx_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                CLK,
    input  logic                RESET_N,
    dlx_mem_responder_if.slave  bus,
    output logic                BUSY,
    input  logic                HOST_WE,
    input  logic [ADDR_W-1:0]   HOST_ADDR,
    input  logic [31:0]         HOST_DIN,
    output logic                HOST_STALL,
    output logic                ERR
);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_RELEASE} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [31:0] addr_reg;
    logic [31:0] data_reg;
    logic        wr_reg;
    logic [31:0] di_reg;
    logic        ack_n_reg;
    logic        busy_reg;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    logic              idle;
    logic              access_go;
    logic              access_wr;
    logic [31:0]       access_addr;
    logic [31:0]       access_data;
    logic [ADDR_W-1:0] access_idx;
    logic              host_go;
    logic              oor;

    assign idle = (state_reg == ST_IDLE);

    // The memory access happens on the edge that enters ACK; with zero wait
    // states that is the capture edge itself, so use the live bus values.
    assign access_go   = RESET_N &&
                         ((idle && !bus.AS_N && WAIT_STATES == 0) ||
                          (state_reg == ST_WAIT && !bus.AS_N && cnt_reg == 4'd1));
    assign access_addr = idle ? bus.AO : addr_reg;
    assign access_data = idle ? bus.DO : data_reg;
    assign access_wr   = idle ? !bus.WR_N : wr_reg;
    assign access_idx  = access_addr[ADDR_W-1:0];

    assign host_go    = RESET_N && HOST_WE && idle && bus.AS_N;
    assign HOST_STALL = RESET_N && HOST_WE && !(idle && bus.AS_N);

`ifdef DLX_MEM_RANGE_CHECK_EN
    logic err_reg;

    assign oor = |access_addr[31:ADDR_W];

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            err_reg <= 1'b0;
        end else if (access_go && oor) begin
            err_reg <= 1'b1;
        end
    end

    assign ERR = err_reg;
`else
    logic unused_upper;

    assign oor          = 1'b0;
    assign unused_upper = ^access_addr[31:ADDR_W];
    assign ERR          = 1'b0;
`endif

    // Memory has no reset so preloaded programs survive a core reset.
    always_ff @(posedge CLK) begin
        if (access_go && access_wr && !oor) begin
            mem[access_idx] <= access_data;
        end else if (host_go) begin
            mem[HOST_ADDR] <= HOST_DIN;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= 32'd0;
            data_reg  <= 32'd0;
            wr_reg    <= 1'b0;
            di_reg    <= 32'd0;
            ack_n_reg <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            ack_n_reg <= 1'b1;
            if (access_go && !access_wr) begin
                di_reg <= oor ? 32'hDEADBEEF : mem[access_idx];
            end
            case (state_reg)
                ST_IDLE: begin
                    if (!bus.AS_N) begin
                        addr_reg <= bus.AO;
                        data_reg <= bus.DO;
                        wr_reg   <= !bus.WR_N;
                        cnt_reg  <= WS;
                        busy_reg <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state_reg <= ST_ACK;
                            ack_n_reg <= 1'b0;
                        end else begin
                            state_reg <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.AS_N) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= 4'd0;
                        busy_reg  <= 1'b0;
                    end else if (cnt_reg == 4'd1) begin
                        state_reg <= ST_ACK;
                        cnt_reg   <= 4'd0;
                        ack_n_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_ACK: begin
                    state_reg <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // A strobe still held low here is the old request, never a new one.
                    if (bus.AS_N) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DI    = di_reg;
    assign bus.ACK_N = ack_n_reg;
    assign BUSY      = busy_reg;
endmodule

// File: tb/tb_dlx_mem_responder.sv
// Self-checking bench for dlx_mem_responder: directed bus/host/reset scenarios plus
// randomized transactions checked against an array-based memory model.
module tb_dlx_mem_responder;
    localparam int AW   = 10;
    localparam int WS   = 2;
    localparam int AW_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    dlx_mem_responder_if bus_a ();
    dlx_mem_responder_if bus_b ();

    logic          busy_a, host_we_a, host_stall_a, err_a;
    logic [AW-1:0] host_addr_a;
    logic [31:0]   host_din_a;
    logic            busy_b, host_we_b, host_stall_b, err_b;
    logic [AW_B-1:0] host_addr_b;
    logic [31:0]     host_din_b;

    dlx_mem_responder #(.ADDR_W(AW), .WAIT_STATES(WS)) dut_a (
        .CLK(clk), .RESET_N(rst_n), .bus(bus_a), .BUSY(busy_a),
        .HOST_WE(host_we_a), .HOST_ADDR(host_addr_a), .HOST_DIN(host_din_a),
        .HOST_STALL(host_stall_a), .ERR(err_a)
    );

    dlx_mem_responder #(.ADDR_W(AW_B), .WAIT_STATES(0)) dut_b (
        .CLK(clk), .RESET_N(rst_n), .bus(bus_b), .BUSY(busy_b),
        .HOST_WE(host_we_b), .HOST_ADDR(host_addr_b), .HOST_DIN(host_din_b),
        .HOST_STALL(host_stall_b), .ERR(err_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference: what each word of dut_a should hold, the last read value, sticky error.
    logic [31:0] mem_model [0:(1<<AW)-1];
    logic [31:0] last_di;
    logic        err_model;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    task automatic host_a(input logic [AW-1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        host_we_a = 1'b1; host_addr_a = a; host_din_a = d;
        @(negedge clk);
        chk1("host_stall_idle", host_stall_a, 1'b0);
        @(posedge clk); #1;
        host_we_a = 1'b0;
        mem_model[a] = d;
    endtask

    // One full bus transaction on dut_a, optionally with a competing host write.
    task automatic txn_a(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic hreq, input logic [AW-1:0] haddr, input logic [31:0] hdata);
        logic [AW-1:0] idx;
        logic          oor;
        logic [31:0]   exp_di;
        int            lat;
        bit            got;
        idx = addr[AW-1:0];
`ifdef DLX_MEM_RANGE_CHECK_EN
        oor = |addr[31:AW];
`else
        oor = 1'b0;
`endif
        exp_di = wr ? last_di : (oor ? 32'hDEADBEEF : mem_model[idx]);
        @(posedge clk); #1;
        bus_a.AS_N = 1'b0; bus_a.WR_N = ~wr; bus_a.AO = addr; bus_a.DO = data;
        if (hreq) begin
            host_we_a = 1'b1; host_addr_a = haddr; host_din_a = hdata;
        end
        @(negedge clk);
        chk1("ack_pre_capture", bus_a.ACK_N, 1'b1);
        chk1("stall_pre_capture", host_stall_a, hreq);
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (c == 1) chk1("busy_rise", busy_a, 1'b1);
            chk1("stall_during_bus", host_stall_a, hreq);
            if (bus_a.ACK_N == 1'b0) begin
                got = 1'b1;
                lat = c;
            end
        end
        chk("ack_latency", 32'(lat), 32'(WS + 1));
        chk("di_at_ack", bus_a.DI, exp_di);
        @(negedge clk);
        chk1("ack_one_cycle", bus_a.ACK_N, 1'b1);
        @(posedge clk); #1;
        bus_a.AS_N = 1'b1;
        @(negedge clk);
        chk1("busy_in_release", busy_a, 1'b1);
        chk1("stall_in_release", host_stall_a, hreq);
        @(negedge clk);
        chk1("busy_fall", busy_a, 1'b0);
        chk1("stall_back_idle", host_stall_a, 1'b0);
        if (wr && !oor) mem_model[idx] = data;
        last_di = exp_di;
        err_model = err_model | oor;
        chk1("err_flag", err_a, err_model);
        if (hreq) begin
            @(posedge clk); #1;
            host_we_a = 1'b0;
            mem_model[haddr] = hdata;
        end
        $display("txn %s ao=%h data=%h lat=%0d", wr ? "WR" : "RD", addr, wr ? data : bus_a.DI, lat);
    endtask

    task automatic rd_a(input logic [31:0] addr);
        txn_a(1'b0, addr, 32'd0, 1'b0, '0, 32'd0);
    endtask

    task automatic wr_a(input logic [31:0] addr, input logic [31:0] data);
        txn_a(1'b1, addr, data, 1'b0, '0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, up, d, vb;
        int          idx;

        // Reset held with AS_N low and a host request pending.
        rst_n = 1'b0;
        last_di = 32'd0;
        err_model = 1'b0;
        bus_a.AS_N = 1'b0; bus_a.WR_N = 1'b1; bus_a.AO = 32'd1; bus_a.DO = 32'd0;
        bus_b.AS_N = 1'b0; bus_b.WR_N = 1'b1; bus_b.AO = 32'd1; bus_b.DO = 32'd0;
        host_we_a = 1'b1; host_addr_a = '0; host_din_a = 32'd0;
        host_we_b = 1'b0; host_addr_b = '0; host_din_b = 32'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk1("rst_ack_n", bus_a.ACK_N, 1'b1);
            chk("rst_di", bus_a.DI, 32'd0);
            chk1("rst_busy", busy_a, 1'b0);
            chk1("rst_stall", host_stall_a, 1'b0);
            chk1("rst_err", err_a, 1'b0);
            chk1("rst_busy_b", busy_b, 1'b0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; bus_a.AS_N = 1'b1; bus_b.AS_N = 1'b1; host_we_a = 1'b0;
        @(negedge clk);
        chk1("post_rst_busy", busy_a, 1'b0);

        for (int i = 0; i < 64; i++) host_a(AW'(i), $urandom);

        // Write then read with two wait states.
        wr_a(32'd5, 32'hCAFE0001);
        rd_a(32'd5);

        // Abort during WAIT of a write to word 7.
        @(posedge clk); #1;
        bus_a.AS_N = 1'b0; bus_a.WR_N = 1'b0; bus_a.AO = 32'd7; bus_a.DO = 32'h0BAD0BAD;
        @(posedge clk); #1;
        bus_a.AS_N = 1'b1;
        @(negedge clk);
        chk1("abort_busy_wait", busy_a, 1'b1);
        @(negedge clk);
        chk1("abort_busy_fall", busy_a, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk1("abort_no_ack", bus_a.ACK_N, 1'b1);
        end
        rd_a(32'd7);

        // Host and bus contend in the same cycle; bus wins, host lands afterwards.
        txn_a(1'b0, 32'd3, 32'd0, 1'b1, AW'(3), 32'h5A5A0003);
        rd_a(32'd3);

        // Reset during WAIT drops the pending write.
        @(posedge clk); #1;
        bus_a.AS_N = 1'b0; bus_a.WR_N = 1'b0; bus_a.AO = 32'd9; bus_a.DO = 32'h99999999;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; bus_a.AS_N = 1'b1;
        last_di = 32'd0;
        err_model = 1'b0;
        @(negedge clk);
        chk1("midrst_busy", busy_a, 1'b0);
        chk("midrst_di", bus_a.DI, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk1("midrst_no_ack", bus_a.ACK_N, 1'b1);
        end
        rd_a(32'd9);

        // Zero wait states on dut_b: ACK in cycle 1 only, AS_N held low for 4 cycles.
        vb = $urandom;
        @(posedge clk); #1;
        host_we_b = 1'b1; host_addr_b = AW_B'(2); host_din_b = vb;
        @(posedge clk); #1;
        host_we_b = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            bus_b.AS_N = 1'b0; bus_b.WR_N = 1'b1; bus_b.AO = 32'd2; bus_b.DO = 32'd0;
            @(negedge clk);
            chk1("zw_ack_pre", bus_b.ACK_N, 1'b1);
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                chk1("zw_ack_window", bus_b.ACK_N, (c == 1) ? 1'b0 : 1'b1);
                if (c == 1) chk("zw_di", bus_b.DI, vb);
            end
            @(posedge clk); #1;
            bus_b.AS_N = 1'b1;
            @(negedge clk);
            chk1("zw_busy_release", busy_b, 1'b1);
            @(negedge clk);
            chk1("zw_busy_fall", busy_b, 1'b0);
            $display("txn RD(b) ao=%h data=%h lat=1", 32'd2, vb);
            // Second pass: overwrite with a zero-wait bus write before re-reading.
            if (pass == 0) begin
                vb = $urandom;
                @(posedge clk); #1;
                bus_b.AS_N = 1'b0; bus_b.WR_N = 1'b0; bus_b.AO = 32'd2; bus_b.DO = vb;
                @(negedge clk);
                @(negedge clk);
                chk1("zw_wr_ack", bus_b.ACK_N, 1'b0);
                @(posedge clk); #1;
                bus_b.AS_N = 1'b1;
                @(negedge clk);
                @(negedge clk);
                $display("txn WR(b) ao=%h data=%h lat=1", 32'd2, vb);
                @(posedge clk); #1;
            end
        end

`ifdef DLX_MEM_RANGE_CHECK_EN
        rd_a(32'h400);
        wr_a(32'h400, 32'h12345678);
        rd_a(32'h0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            idx = int'($urandom_range(0, 63));
            up  = $urandom;
`ifdef DLX_MEM_RANGE_CHECK_EN
            if ($urandom_range(0, 7) != 0) up = 32'd0;
            else up[31] = 1'b1;
`endif
            a = {up[31:AW], AW'(idx)};
            d = $urandom;
            if ($urandom_range(0, 3) == 0) host_a(AW'($urandom_range(0, 63)), $urandom);
            if ($urandom_range(0, 1) == 0) wr_a(a, d);
            else rd_a(a);
        end

        chk1("final_err", err_a, err_model);
        chk1("final_err_b", err_b, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
